interval_polygon: RTL and testbench
===================================

# interval_polygon

Sequential scanline interval generator for a convex polygon of up to NV vertices, generalising the fixed square span block to arbitrary convex pieces (triangles, rotated squares, parallelograms). For each requested line y it walks the polygon edges one per step, intersects each edge with the line using a shared multi-cycle divider, and returns the covered span [s, t]. It sits in the render path between the piece-geometry registers and the per-line fill logic; the span outputs use the same empty-interval encoding (s=1, t=0) as the existing interval blocks.

## Interface
- CORDW, 10, coordinate width in bits (unsigned screen coordinates)
- NV, 4, vertex count (>=3); repeated vertices allowed for pieces with fewer corners
- clk  in  1  pixel-domain clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only when busy=0
- y  in  CORDW  line to evaluate; latched on accepted start
- vx  in  NV x CORDW  vertex x coordinates, polygon order; latched on accepted start
- vy  in  NV x CORDW  vertex y coordinates; latched on accepted start
- busy  out  1  high from the cycle after accepted start through the done cycle
- done  out  1  one-cycle pulse; s/t valid from this cycle
- s  out  CORDW  span start (inclusive)
- t  out  CORDW  span end (inclusive); s>t means empty

## Operation
- States: IDLE, EDGE, DIV, MERGE, DONE.
- IDLE: start=1 latches y, vx, vy; clears accumulators (min=all-ones, max=0, hit=0); edge index i=0; -> EDGE.
- EDGE (1 cycle): edge a=i, b=(i+1) mod NV.
  - Horizontal (vy[a]==vy[b]): if y==vy[a], merge min(vx[a],vx[b]) and max(...), set hit. No division. Next edge or DONE.
  - Non-horizontal, y within [min(vy),max(vy)] inclusive: start divider with num=|y-vy[a]|*|vx[b]-vx[a]| (2*CORDW bits), den=|vy[b]-vy[a]| (CORDW bits); -> DIV. Vertical edges (zero numerator) still divide: timing is uniform.
  - Otherwise: no contribution; next edge or DONE.
- DIV: wait 2*CORDW cycles for divider quotient q (truncated).
- MERGE (1 cycle): x = vx[a]+q if vx[b]>=vx[a], else vx[a]-q; merge into min/max, set hit; next edge or DONE.
- DONE (1 cycle): done=1; s/t <= hit ? (min,max) : (1,0); -> IDLE.
- Intersection always lies between vx[a] and vx[b]; no overflow, no clamping.
- start while busy=1 (including DONE cycle): ignored.
- Input changes after the accepted start have no effect.
- Concave/self-intersecting input: undefined span, but the block must still terminate with the same latency formula.

## Timing
- Reset (async assert, sync release): state IDLE, busy=0, done=0, s=1, t=0, divider idle. Reset mid-operation aborts immediately; no done pulse follows.
- start accepted in cycle 0 -> done in cycle L = NV + 1 + D*(2*CORDW+1), D = edges requiring division.
- busy high cycles 1..L; a new start is accepted in cycle L+1 at earliest.
- s/t registered; change only in the DONE cycle; hold otherwise.

## Structure
- Package interval_pkg: state enum, EMPTY_S=1, EMPTY_T=0 constants, shared with the other interval blocks.
- Sub-module interval_divu: unsigned restoring divider, 2*CORDW-bit dividend / CORDW-bit divisor, fixed 2*CORDW-cycle latency, start/done handshake, async active-low reset. Division by zero cannot occur (horizontal edges bypass).

## Test plan
- Square (100,100),(150,100),(150,150),(100,150), y=120 -> s=100, t=150, D=2, done at cycle 47 (CORDW=10).
- Same square, y=100 (horizontal edge plus vertical endpoints) -> s=100, t=150, done at cycle 47; y=99 -> s=1, t=0, done at cycle 5.
- Triangle (0,0),(100,0),(0,100),(0,100), y=50 -> s=0, t=50; y=100 -> s=0, t=0 (zero-length edge hit).
- Truncation: (0,0),(10,3),(0,3),(0,3), y=1 -> s=0, t=3.
- start pulsed during busy and vx/vy/y changed mid-run -> ignored; result matches the latched request; back-to-back start at cycle L+1 accepted.
- rst_n asserted in DIV -> busy=0, done=0, s=1, t=0 immediately; no done pulse; next start completes normally.

Source files
------------

// File: rtl/interval_pkg.sv
// Shared definitions for the scanline interval blocks.
// State encoding and the empty-span (s=1, t=0) constants.
package interval_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDGE,
    S_DIV,
    S_MERGE,
    S_DONE
  } ipoly_state_t;

  localparam int EMPTY_S = 1;
  localparam int EMPTY_T = 0;

endpackage

// File: rtl/interval_divu.sv
// Unsigned restoring divider, 2W-bit dividend / W-bit divisor, 2W cycles.
// Ports: clk, rst_n, start, num, den -> done (pulse), q (low W bits).
module interval_divu
  #(parameter int W = 10)
  (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] num,
  input  logic [W-1:0]   den,
  output logic           done,
  output logic [W-1:0]   q
);

  localparam int NW = 2 * W;
  localparam int KW = $clog2(NW + 1);

  logic [W-1:0]  rem;
  logic [W-1:0]  dv;
  logic [NW-1:0] quo;
  logic [KW-1:0] cnt;
  logic          run;
  logic [W:0]    sh;
  logic          ge;

  // Remainder stays below the divisor, so W bits hold it
  // and one extra bit covers the shifted trial value.
  assign sh = {rem, quo[NW-1]};
  assign ge = (sh >= {1'b0, dv});
  // Callers guarantee the quotient fits in W bits.
  assign q  = quo[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      dv   <= '0;
      quo  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem <= '0;
        quo <= num;
        dv  <= den;
        cnt <= KW'(NW);
        run <= 1'b1;
      end else if (run) begin
        rem <= ge ? W'(sh - {1'b0, dv}) : sh[W-1:0];
        quo <= {quo[NW-2:0], ge};
        cnt <= cnt - 1'b1;
        if (cnt == KW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/interval_polygon.sv
// Scanline span [s,t] of a convex polygon at line y, one edge per step.
// Ports: start/y/vx/vy in (latched), busy/done/s/t out (registered).
module interval_polygon
  import interval_pkg::*;
  #(
  parameter int CORDW = 10,
  parameter int NV    = 4
  )
  (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CORDW-1:0]    y,
  input  logic [NV*CORDW-1:0] vx,
  input  logic [NV*CORDW-1:0] vy,
  output logic                busy,
  output logic                done,
  output logic [CORDW-1:0]    s,
  output logic [CORDW-1:0]    t
);

  localparam int IW = (NV > 1) ? $clog2(NV) : 1;
  localparam int DW = 2 * CORDW;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] DLAST = CW'(DW - 1);
  localparam logic [IW-1:0] ILAST = IW'(NV - 1);

  ipoly_state_t state;

  logic [CORDW-1:0]    yr;
  logic [NV*CORDW-1:0] vxr;
  logic [NV*CORDW-1:0] vyr;
  logic [IW-1:0]       i;
  logic [CW-1:0]       dcnt;
  logic [CORDW-1:0]    minx;
  logic [CORDW-1:0]    maxx;
  logic                hit;

  logic             last;
  logic [IW-1:0]    ib;
  logic [CORDW-1:0] xa, xb, ya, yb;
  logic [CORDW-1:0] ylo, yhi;
  logic [CORDW-1:0] dya, dx, den;
  logic [DW-1:0]    num;
  logic             horiz;
  logic             inrange;
  logic             div_start;
  logic             div_done;
  logic [CORDW-1:0] q;
  logic [CORDW-1:0] x;

  logic             men;
  logic [CORDW-1:0] mlo, mhi;
  logic [CORDW-1:0] nmin, nmax;
  logic             nhit;

  assign last = (i == ILAST);
  assign ib   = last ? '0 : i + 1'b1;

  assign xa = vxr[i*CORDW +: CORDW];
  assign xb = vxr[ib*CORDW +: CORDW];
  assign ya = vyr[i*CORDW +: CORDW];
  assign yb = vyr[ib*CORDW +: CORDW];

  assign ylo     = (ya < yb) ? ya : yb;
  assign yhi     = (ya < yb) ? yb : ya;
  assign horiz   = (ya == yb);
  assign inrange = (yr >= ylo) && (yr <= yhi);

  assign dya = (yr >= ya) ? yr - ya : ya - yr;
  assign dx  = (xb >= xa) ? xb - xa : xa - xb;
  assign den = yhi - ylo;
  assign num = DW'(dya) * DW'(dx);

  // Vertical edges still divide (num=0) to keep latency uniform.
  assign div_start = (state == S_EDGE) && !horiz && inrange;

  // The intersection lies between xa and xb, so no wrap occurs.
  assign x = (xb >= xa) ? xa + q : xa - q;

  interval_divu #(.W(CORDW)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (num),
    .den   (den),
    .done  (div_done),
    .q     (q)
  );

  always_comb begin
    men = 1'b0;
    mlo = xa;
    mhi = xb;
    unique case (1'b1)
      (state == S_EDGE): begin
        if (horiz && (yr == ya)) begin
          men = 1'b1;
          mlo = (xa < xb) ? xa : xb;
          mhi = (xa < xb) ? xb : xa;
        end
      end
      (state == S_MERGE): begin
        if (div_done) begin
          men = 1'b1;
          mlo = x;
          mhi = x;
        end
      end
      default: ;
    endcase
    nmin = (men && (mlo < minx)) ? mlo : minx;
    nmax = (men && (mhi > maxx)) ? mhi : maxx;
    nhit = hit | men;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= CORDW'(EMPTY_S);
      t     <= CORDW'(EMPTY_T);
      yr    <= '0;
      vxr   <= '0;
      vyr   <= '0;
      i     <= '0;
      dcnt  <= '0;
      minx  <= '1;
      maxx  <= '0;
      hit   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            yr    <= y;
            vxr   <= vx;
            vyr   <= vy;
            minx  <= '1;
            maxx  <= '0;
            hit   <= 1'b0;
            i     <= '0;
            busy  <= 1'b1;
            state <= S_EDGE;
          end
        end
        S_EDGE, S_MERGE: begin
          minx <= nmin;
          maxx <= nmax;
          hit  <= nhit;
          if (div_start) begin
            dcnt  <= '0;
            state <= S_DIV;
          end else if (last) begin
            done  <= 1'b1;
            s     <= nhit ? nmin : CORDW'(EMPTY_S);
            t     <= nhit ? nmax : CORDW'(EMPTY_T);
            state <= S_DONE;
          end else begin
            i     <= i + 1'b1;
            state <= S_EDGE;
          end
        end
        S_DIV: begin
          if (dcnt == DLAST) begin
            state <= S_MERGE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interval_polygon.sv
// Directed bench for interval_polygon (CORDW=10, NV=4).
// Hand-computed spans and latencies; prints CHECKS/ERRORS summary.
module tb_interval_polygon;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  y;
  logic [39:0] vx;
  logic [39:0] vy;
  logic        busy;
  logic        done;
  logic [9:0]  s;
  logic [9:0]  t;

  int checks;
  int errors;

  // Vertex k sits at bits [10k +: 10]: {v3, v2, v1, v0}.
  localparam logic [39:0] SQX =
    {10'd100, 10'd150, 10'd150, 10'd100};
  localparam logic [39:0] SQY =
    {10'd150, 10'd150, 10'd100, 10'd100};
  localparam logic [39:0] TRX =
    {10'd0, 10'd0, 10'd100, 10'd0};
  localparam logic [39:0] TRY =
    {10'd100, 10'd100, 10'd0, 10'd0};
  localparam logic [39:0] TCX =
    {10'd0, 10'd0, 10'd10, 10'd0};
  localparam logic [39:0] TCY =
    {10'd3, 10'd3, 10'd3, 10'd0};

  interval_polygon #(.CORDW(10), .NV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .y     (y),
    .vx    (vx),
    .vy    (vy),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .t     (t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called mid-cycle 0 with the block idle; returns mid-cycle L.
  task automatic run_op(
    input string      nm,
    input logic [9:0] yy,
    input logic [39:0] xx,
    input logic [39:0] yv,
    input int         el,
    input logic [9:0] es,
    input logic [9:0] et,
    input int         poke,
    input bit         poke_done
  );
    int         k;
    bit         got;
    bit         busy_bad;
    bit         hold_bad;
    logic [9:0] s0;
    logic [9:0] t0;
    s0 = s;
    t0 = t;
    start = 1'b1;
    y  = yy;
    vx = xx;
    vy = yv;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    got = 1'b0;
    busy_bad = 1'b0;
    hold_bad = 1'b0;
    while (k <= 300) begin
      if (!busy) busy_bad = 1'b1;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (s !== s0 || t !== t0) hold_bad = 1'b1;
      if (k == poke) begin
        start = 1'b1;
        y  = ~yy;
        vx = ~xx;
        vy = ~yv;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no done in %0d cycles", nm, k);
    end else begin
      if (poke_done) start = 1'b1;
      checks++;
      if (k !== el) begin
        errors++;
        $display("FAIL %s latency: got %0d want %0d", nm, k, el);
      end
      checks++;
      if (s !== es) begin
        errors++;
        $display("FAIL %s s: got %0d want %0d", nm, s, es);
      end
      checks++;
      if (t !== et) begin
        errors++;
        $display("FAIL %s t: got %0d want %0d", nm, t, et);
      end
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL %s busy: got low want high while running", nm);
    end
    checks++;
    if (hold_bad) begin
      errors++;
      $display("FAIL %s hold: s/t moved before done, want %0d/%0d",
               nm, s0, t0);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset busy: got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset done: got %b want 0", done);
    end
    checks++;
    if (s !== 10'd1) begin
      errors++;
      $display("FAIL reset s: got %0d want 1", s);
    end
    checks++;
    if (t !== 10'd0) begin
      errors++;
      $display("FAIL reset t: got %0d want 0", t);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset idle: busy=%b done=%b want 0 0",
               busy, done);
    end
  endtask

  task automatic test_square;
    @(negedge clk);
    run_op("sq_y120", 10'd120, SQX, SQY, 47,
           10'd100, 10'd150, -1, 1'b0);
    @(negedge clk);
    run_op("sq_y100", 10'd100, SQX, SQY, 47,
           10'd100, 10'd150, -1, 1'b0);
    @(negedge clk);
    run_op("sq_y99", 10'd99, SQX, SQY, 5,
           10'd1, 10'd0, -1, 1'b0);
  endtask

  task automatic test_triangle;
    @(negedge clk);
    run_op("tri_y50", 10'd50, TRX, TRY, 47,
           10'd0, 10'd50, -1, 1'b0);
    @(negedge clk);
    run_op("tri_y100", 10'd100, TRX, TRY, 47,
           10'd0, 10'd0, -1, 1'b0);
  endtask

  task automatic test_truncation;
    @(negedge clk);
    run_op("trunc", 10'd1, TCX, TCY, 47,
           10'd0, 10'd3, -1, 1'b0);
  endtask

  task automatic test_ignore_midrun;
    @(negedge clk);
    run_op("midrun", 10'd120, SQX, SQY, 47,
           10'd100, 10'd150, 5, 1'b1);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL done_start: busy=%b done=%b want 0 0",
               busy, done);
    end
  endtask

  // Starts in cycle L+1 of the previous request.
  task automatic test_back_to_back;
    run_op("b2b_a", 10'd1, TCX, TCY, 47,
           10'd0, 10'd3, -1, 1'b0);
    @(negedge clk);
    run_op("b2b_b", 10'd99, SQX, SQY, 5,
           10'd1, 10'd0, -1, 1'b0);
  endtask

  task automatic test_reset_mid_div;
    bit seen;
    @(negedge clk);
    run_op("pre_rst", 10'd50, TRX, TRY, 47,
           10'd0, 10'd50, -1, 1'b0);
    @(negedge clk);
    start = 1'b1;
    y  = 10'd120;
    vx = SQX;
    vy = SQY;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_div flags: busy=%b done=%b want 0 0",
               busy, done);
    end
    checks++;
    if (s !== 10'd1 || t !== 10'd0) begin
      errors++;
      $display("FAIL rst_div span: s=%0d t=%0d want 1 0", s, t);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_div ghost: done/busy got 1 want 0");
    end
    run_op("post_rst", 10'd100, TRX, TRY, 47,
           10'd0, 10'd0, -1, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    y      = '0;
    vx     = '0;
    vy     = '0;
    test_reset;
    test_square;
    test_triangle;
    test_truncation;
    test_ignore_midrun;
    test_back_to_back;
    test_reset_mid_div;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
